sram_arbiter: RTL and testbench

Two-port access sequencer sitting directly upstream of the external SRAM strobe controller. It arbitrates between a CPU port (read/write) and a video fetch port (read-only). It latches address and write data, issues one-cycle read/write commands to the strobe controller, captures read data at the end of the strobe window, and acknowledges the requester. SRAM accesses are serialised at one access per 5 cycles.

---
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port (CPU r/w, video r/o) access sequencer feeding the SRAM strobe controller.
// One access per 5 cycles: IDLE -> STROBE -> ACT1 -> ACT2 -> DONE.
module sram_arbiter #(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 8
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iCpuRd,
    input  logic          iCpuWr,
    input  logic [AW-1:0] iCpuAddr,
    input  logic [DW-1:0] iCpuData,
    output logic [DW-1:0] oCpuData,
    output logic          oCpuAck,
    input  logic          iVidRd,
    input  logic [AW-1:0] iVidAddr,
    output logic [DW-1:0] oVidData,
    output logic          oVidAck,
    output logic          oRd,
    output logic          oWr,
    output logic [AW-1:0] oSramAddr,
    output logic [DW-1:0] oSramData,
    input  logic [DW-1:0] iSramData
);

    typedef enum logic [2:0] {StIdle, StStrobe, StAct1, StAct2, StDone} state_e;

    state_e        state_q;
    logic          owner_vid_q;
    logic          kind_wr_q;
    logic          cpu_turn_q;
    logic          just_done_q;
    logic          rd_q;
    logic          wr_q;
    logic          cpu_ack_q;
    logic          vid_ack_q;
    logic [DW-1:0] cpu_data_q;
    logic [DW-1:0] vid_data_q;
    logic [AW-1:0] sram_addr_q;
    logic [DW-1:0] sram_data_q;

    logic cpu_req;
    logic cpu_elig;
    logic vid_elig;
    logic grant_vid;
    logic grant_cpu;

    // The port acked in the previous cycle is masked so a one-cycle-late drop is harmless.
    always_comb begin
        cpu_req   = iCpuRd | iCpuWr;
        cpu_elig  = cpu_req & ~(just_done_q & ~owner_vid_q);
        vid_elig  = iVidRd & ~(just_done_q & owner_vid_q);
        grant_vid = vid_elig & ~(cpu_elig & cpu_turn_q);
        grant_cpu = cpu_elig & ~grant_vid;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= StIdle;
            owner_vid_q <= 1'b0;
            kind_wr_q   <= 1'b0;
            cpu_turn_q  <= 1'b0;
            just_done_q <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_data_q  <= '0;
            vid_data_q  <= '0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
        end else begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            just_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_vid) begin
                        owner_vid_q <= 1'b1;
                        kind_wr_q   <= 1'b0;
                        sram_addr_q <= iVidAddr;
                        rd_q        <= 1'b1;
                        // A waiting CPU gets the next contested slot.
                        cpu_turn_q  <= cpu_elig;
                        state_q     <= StStrobe;
                    end else if (grant_cpu) begin
                        owner_vid_q <= 1'b0;
                        kind_wr_q   <= iCpuWr;
                        sram_addr_q <= iCpuAddr;
                        sram_data_q <= iCpuData;
                        rd_q        <= ~iCpuWr;
                        wr_q        <= iCpuWr;
                        cpu_turn_q  <= 1'b0;
                        state_q     <= StStrobe;
                    end
                end
                StStrobe: state_q <= StAct1;
                StAct1:   state_q <= StAct2;
                StAct2: begin
                    if (!kind_wr_q) begin
                        if (owner_vid_q) vid_data_q <= iSramData;
                        else             cpu_data_q <= iSramData;
                    end
                    cpu_ack_q <= ~owner_vid_q;
                    vid_ack_q <= owner_vid_q;
                    state_q   <= StDone;
                end
                StDone: begin
                    just_done_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oCpuData  = cpu_data_q;
    assign oCpuAck   = cpu_ack_q;
    assign oVidData  = vid_data_q;
    assign oVidAck   = vid_ack_q;
    assign oRd       = rd_q;
    assign oWr       = wr_q;
    assign oSramAddr = sram_addr_q;
    assign oSramData = sram_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an ack-ordered scoreboard and a 2-cycle OE SRAM model.
module tb_sram_arbiter;

    logic        iClk;
    logic        iRst;
    logic        iCpuRd;
    logic        iCpuWr;
    logic [19:0] iCpuAddr;
    logic [7:0]  iCpuData;
    logic [7:0]  oCpuData;
    logic        oCpuAck;
    logic        iVidRd;
    logic [19:0] iVidAddr;
    logic [7:0]  oVidData;
    logic        oVidAck;
    logic        oRd;
    logic        oWr;
    logic [19:0] oSramAddr;
    logic [7:0]  oSramData;
    logic [7:0]  iSramData;

    sram_arbiter #(.AW(20), .DW(8)) dut (
        .iClk(iClk), .iRst(iRst),
        .iCpuRd(iCpuRd), .iCpuWr(iCpuWr), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
        .oCpuData(oCpuData), .oCpuAck(oCpuAck),
        .iVidRd(iVidRd), .iVidAddr(iVidAddr), .oVidData(oVidData), .oVidAck(oVidAck),
        .oRd(oRd), .oWr(oWr), .oSramAddr(oSramAddr), .oSramData(oSramData),
        .iSramData(iSramData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Controller keeps OE active for the two cycles following an oRd strobe.
    logic [1:0] oe_cnt = 2'd0;
    always_ff @(posedge iClk) begin
        if (oRd)               oe_cnt <= 2'd2;
        else if (oe_cnt != 0)  oe_cnt <= oe_cnt - 2'd1;
    end

    function automatic logic [7:0] mem_f(input logic [19:0] a);
        case (a)
            20'h00010: return 8'h3C;
            20'h00100: return 8'h5A;
            20'h00200: return 8'hC3;
            default:   return a[7:0] ^ 8'h96;
        endcase
    endfunction

    assign iSramData = (oe_cnt != 0) ? mem_f(oSramAddr) : 8'hEE;

    typedef struct {
        logic       vid;
        logic       wr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] cpu_m;
    logic [7:0] vid_m;
    logic [7:0] prev_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge iClk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            chk("idle_quiet", 32'({oRd, oWr, oCpuAck, oVidAck}), 32'd0);
        end
    endtask

    task automatic push(input logic vid, input logic wr, input logic [7:0] data);
        exp_t e;
        e.vid  = vid;
        e.wr   = wr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, 32'({oRd, oWr, oCpuAck, oVidAck}), 32'd0);
        chk({tag, "_cpu_data"}, 32'(oCpuData), 32'd0);
        chk({tag, "_vid_data"}, 32'(oVidData), 32'd0);
        chk({tag, "_addr"}, 32'(oSramAddr), 32'd0);
        chk({tag, "_wdata"}, 32'(oSramData), 32'd0);
    endtask

    // Strobe rules and ack scoreboard, sampled on the falling edge.
    initial begin
        logic prev_rd;
        logic prev_wr;
        exp_t e;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        forever begin
            @(negedge iClk);
            if (oRd || oWr) begin
                chk("strobe_excl", 32'(oRd & oWr), 32'd0);
                chk("strobe_consec", 32'((oRd & prev_rd) | (oWr & prev_wr)), 32'd0);
            end
            if (oCpuAck || oVidAck) begin
                chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_port", 32'({oVidAck, oCpuAck}), 32'({e.vid, ~e.vid}));
                    if (e.vid)       vid_m = e.data;
                    else if (!e.wr)  cpu_m = e.data;
                    chk("sb_cpu_data", 32'(oCpuData), 32'(cpu_m));
                    chk("sb_vid_data", 32'(oVidData), 32'(vid_m));
                end
            end
            prev_rd = oRd;
            prev_wr = oWr;
        end
    end

    initial begin
        iRst = 1'b1; iCpuRd = 1'b0; iCpuWr = 1'b0; iCpuAddr = '0; iCpuData = '0;
        iVidRd = 1'b0; iVidAddr = '0;
        cpu_m = '0; vid_m = '0;
        repeat (3) step();
        chk_all_zero("reset");
        iRst = 1'b0;
        idle(2);

        // CPU write
        iCpuWr = 1'b1; iCpuAddr = 20'h12345; iCpuData = 8'hA5;
        push(1'b0, 1'b1, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("wr_oWr", 32'(oWr), 32'(k == 1));
            chk("wr_oRd", 32'(oRd), 32'd0);
            chk("wr_addr", 32'(oSramAddr), 32'h12345);
            chk("wr_data", 32'(oSramData), 32'hA5);
            chk("wr_ack", 32'(oCpuAck), 32'(k == 4));
        end
        iCpuWr = 1'b0;
        idle(3);

        // CPU read, then requester drops one cycle late
        prev_d = oVidData;
        iCpuRd = 1'b1; iCpuAddr = 20'h00010;
        push(1'b0, 1'b0, 8'h3C);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rd_oRd", 32'(oRd), 32'(k == 1));
            chk("rd_ack", 32'(oCpuAck), 32'(k == 4));
        end
        chk("rd_data", 32'(oCpuData), 32'h3C);
        chk("rd_vid_hold", 32'(oVidData), 32'(prev_d));
        step();
        chk("late_quiet5", 32'({oRd, oWr}), 32'd0);
        step();
        chk("late_quiet6", 32'({oRd, oWr}), 32'd0);
        iCpuRd = 1'b0;
        idle(4);

        // Contention: both held, video wins first, then strict alternation
        iVidRd = 1'b1; iVidAddr = 20'h00100;
        iCpuRd = 1'b1; iCpuAddr = 20'h00200;
        push(1'b1, 1'b0, 8'h5A); push(1'b0, 1'b0, 8'hC3);
        push(1'b1, 1'b0, 8'h5A); push(1'b0, 1'b0, 8'hC3);
        for (int k = 1; k <= 19; k++) begin
            step();
            chk("cont_oRd", 32'(oRd), 32'(k % 5 == 1));
            chk("cont_vid_ack", 32'(oVidAck), 32'(k == 4 || k == 14));
            chk("cont_cpu_ack", 32'(oCpuAck), 32'(k == 9 || k == 19));
        end
        iVidRd = 1'b0; iCpuRd = 1'b0;
        idle(3);

        // CPU passed over by video keeps priority for the next contested IDLE
        iVidRd = 1'b1; iCpuRd = 1'b1;
        push(1'b1, 1'b0, 8'h5A);
        repeat (4) step();
        chk("hist_vid_ack", 32'({oVidAck, oCpuAck}), 32'b10);
        iVidRd = 1'b0; iCpuRd = 1'b0;
        step();
        chk("hist_gap", 32'({oRd, oWr}), 32'd0);
        iVidRd = 1'b1; iCpuRd = 1'b1;
        push(1'b0, 1'b0, 8'hC3); push(1'b1, 1'b0, 8'h5A);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("hist_cpu_ack", 32'(oCpuAck), 32'(k == 4));
            chk("hist_vid_ack2", 32'(oVidAck), 32'(k == 9));
            if (k == 4) iCpuRd = 1'b0;
        end
        iVidRd = 1'b0;
        idle(3);

        // Read and write together act as a write
        prev_d = oCpuData;
        iCpuRd = 1'b1; iCpuWr = 1'b1; iCpuAddr = 20'h00005; iCpuData = 8'h77;
        push(1'b0, 1'b1, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rw_oWr", 32'(oWr), 32'(k == 1));
            chk("rw_oRd", 32'(oRd), 32'd0);
            chk("rw_ack", 32'(oCpuAck), 32'(k == 4));
        end
        chk("rw_cpu_hold", 32'(oCpuData), 32'(prev_d));
        chk("rw_wdata", 32'(oSramData), 32'h77);
        iCpuRd = 1'b0; iCpuWr = 1'b0;
        idle(3);

        // Reset during ACT1 of a video read, then a clean CPU read
        iVidRd = 1'b1; iVidAddr = 20'h00300;
        step();
        chk("rst_oRd", 32'(oRd), 32'd1);
        step();
        iRst = 1'b1; iVidRd = 1'b0;
        step();
        chk_all_zero("rst_after");
        cpu_m = '0; vid_m = '0;
        iRst = 1'b0;
        iCpuRd = 1'b1; iCpuAddr = 20'h00010;
        push(1'b0, 1'b0, 8'h3C);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("post_rst_oRd", 32'(oRd), 32'(k == 1));
            chk("post_rst_cpu_ack", 32'(oCpuAck), 32'(k == 4));
            chk("post_rst_vid_ack", 32'(oVidAck), 32'd0);
        end
        chk("post_rst_data", 32'(oCpuData), 32'h3C);
        iCpuRd = 1'b0;
        idle(5);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
